div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_pkg.sv | 14 +
 rtl/div_seq_if.sv | 27 ++
 rtl/div_step.sv | 31 +++
 rtl/div_seq.sv | 152 +++++++++++++++
 tb/tb_div_seq.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding
// and the legal range of the operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } DivState;

  localparam int W_MIN = 2;
  localparam int W_MAX = 32;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle of the sequential divider. The requester drives
// start and the operands; the divider drives status and results.
interface div_seq_if #(
  parameter int W = 8
);

  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] q;
  logic [W-1:0] r;

  modport master (
    output start, sgn, a, b,
    input  busy, done, dz, q, r
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, dz, q, r
  );

endinterface

// File: rtl/div_step.sv
// One restoring division step on magnitudes: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvdBit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         qBit_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // The incoming remainder is always below the divisor (or below 2^k after
  // k steps when dividing by zero), so the (W+1)-bit shifted value never
  // overflows and a kept or restored remainder always fits back in W bits.
  always_comb begin
    shifted = {rem_i, dvdBit_i};
    diff    = shifted - {1'b0, dvs_i};
    if (!diff[W]) begin
      rem_o  = diff[W-1:0];
      qBit_o = 1'b1;
    end else begin
      rem_o  = shifted[W-1:0];
      qBit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, unsigned or two's complement, one quotient
// bit per cycle. A request is captured in IDLE, the operands are turned
// into magnitudes during the following IDLE cycle, W CALC cycles produce
// the magnitude result, and the signed/zero-divisor fix-up is registered
// on entry to DONE.
module div_seq
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int            CW        = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  if (W < W_MIN || W > W_MAX) begin : gBadWidth
    $error("div_seq: W outside the supported range");
  end

  DivState      stateQ, stateD;
  logic         loadQ, loadD;
  logic         sgnQ, sgnD;
  logic [W-1:0] aQ, aD;
  logic [W-1:0] bQ, bD;
  logic [W-1:0] dvdQ, dvdD;
  logic [W-1:0] dvsQ, dvsD;
  logic [W-1:0] remQ, remD;
  logic [CW-1:0] cntQ, cntD;
  logic [W-1:0] qQ, qD;
  logic [W-1:0] rQ, rD;
  logic         dzQ, dzD;

  logic         aNeg, bNeg, qNeg;
  logic [W-1:0] aMag, bMag;
  logic [W-1:0] stepRem;
  logic         stepBit;
  logic [W-1:0] quotMag;

  assign aNeg    = sgnQ & aQ[W-1];
  assign bNeg    = sgnQ & bQ[W-1];
  assign qNeg    = aNeg ^ bNeg;
  assign aMag    = aNeg ? ({W{1'b0}} - aQ) : aQ;
  assign bMag    = bNeg ? ({W{1'b0}} - bQ) : bQ;
  assign quotMag = {dvdQ[W-2:0], stepBit};

  div_step #(.W(W)) uStep (
    .rem_i    (remQ),
    .dvdBit_i (dvdQ[W-1]),
    .dvs_i    (dvsQ),
    .rem_o    (stepRem),
    .qBit_o   (stepBit)
  );

  // Next-state logic: capture in IDLE, load magnitudes on the following
  // edge, iterate in CALC and publish the signed or zero-divisor result.
  always_comb begin
    stateD = stateQ;
    loadD  = loadQ;
    sgnD   = sgnQ;
    aD     = aQ;
    bD     = bQ;
    dvdD   = dvdQ;
    dvsD   = dvsQ;
    remD   = remQ;
    cntD   = cntQ;
    qD     = qQ;
    rD     = rQ;
    dzD    = dzQ;
    case (stateQ)
      IDLE: begin
        if (loadQ) begin
          stateD = CALC;
          loadD  = 1'b0;
          dvdD   = aMag;
          dvsD   = bMag;
          remD   = '0;
          cntD   = '0;
        end else if (bus.start) begin
          loadD = 1'b1;
          sgnD  = bus.sgn;
          aD    = bus.a;
          bD    = bus.b;
        end
      end
      CALC: begin
        remD = stepRem;
        dvdD = quotMag;
        cntD = cntQ + 1'b1;
        if (cntQ == LAST_STEP) begin
          stateD = DONE;
          if (bQ == '0) begin
            dzD = 1'b1;
            qD  = '1;
            rD  = aQ;
          end else begin
            dzD = 1'b0;
            qD  = qNeg ? ({W{1'b0}} - quotMag) : quotMag;
            rD  = aNeg ? ({W{1'b0}} - stepRem) : stepRem;
          end
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // State and datapath registers; a low rst at the edge clears everything
  // and so also aborts any division in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ <= IDLE;
      loadQ  <= 1'b0;
      sgnQ   <= 1'b0;
      aQ     <= '0;
      bQ     <= '0;
      dvdQ   <= '0;
      dvsQ   <= '0;
      remQ   <= '0;
      cntQ   <= '0;
      qQ     <= '0;
      rQ     <= '0;
      dzQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      loadQ  <= loadD;
      sgnQ   <= sgnD;
      aQ     <= aD;
      bQ     <= bD;
      dvdQ   <= dvdD;
      dvsQ   <= dvsD;
      remQ   <= remD;
      cntQ   <= cntD;
      qQ     <= qD;
      rQ     <= rD;
      dzQ    <= dzD;
    end
  end

  assign bus.busy = (stateQ != IDLE);
  assign bus.done = (stateQ == DONE);
  assign bus.dz   = dzQ;
  assign bus.q    = qQ;
  assign bus.r    = rQ;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq at W=8: directed scenarios plus random
// back-to-back operations against an integer-arithmetic reference model.
module tb_div_seq;

  localparam int W = 8;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_seq_if #(.W(W)) dif ();

  div_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference: plain integer division with C-style truncation; a zero
  // divisor yields all ones and the dividend, flagged by dz.
  function automatic void model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] qe, output logic [W-1:0] re, output logic dze);
    int sa;
    int sb;
    if (bv == '0) begin
      qe  = '1;
      re  = av;
      dze = 1'b1;
    end else begin
      if (s) begin
        sa = int'($signed(av));
        sb = int'($signed(bv));
      end else begin
        sa = int'(av);
        sb = int'(bv);
      end
      qe  = W'(sa / sb);
      re  = W'(sa % sb);
      dze = 1'b0;
    end
  endfunction

  // Drives one request (called #1 after a rising edge), waits a bounded
  // number of edges for done, and returns the result, latency in edges
  // after the sampling edge (-1 on timeout) and the number of busy cycles.
  task automatic doOp(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                      output logic [W-1:0] qo, output logic [W-1:0] ro, output logic dzo,
                      output int lat, output int busyCnt);
    dif.start = 1'b1;
    dif.sgn   = s;
    dif.a     = av;
    dif.b     = bv;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    lat = -1;
    busyCnt = 0;
    qo = '0;
    ro = '0;
    dzo = 1'b0;
    if (dif.busy) busyCnt++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (dif.busy) busyCnt++;
      if (dif.done) begin
        lat = k;
        qo  = dif.q;
        ro  = dif.r;
        dzo = dif.dz;
        break;
      end
    end
    if (lat >= 0) begin
      @(posedge clk);
      #1;
      if (dif.busy) busyCnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dif.start = 1'b1;
    dif.sgn = 1'b1;
    dif.a = 8'h12;
    dif.b = 8'h03;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", dif.busy); end
    checks++; if (dif.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", dif.done); end
    checks++; if (dif.dz !== 1'b0) begin errors++; $display("[TB] FAIL reset_dz: got %b expected 0", dif.dz); end
    checks++; if (dif.q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q: got %h expected 00", dif.q); end
    checks++; if (dif.r !== 8'h00) begin errors++; $display("[TB] FAIL reset_r: got %h expected 00", dif.r); end
    dif.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_ignored: busy got %b expected 0", dif.busy); end
  endtask

  task automatic test_unsigned_basic();
    logic [W-1:0] qg, rg;
    logic dzg;
    int lat, bc;
    doOp(1'b0, 8'd100, 8'd7, qg, rg, dzg, lat, bc);
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL u100_7_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bc != LAT) begin errors++; $display("[TB] FAIL u100_7_busy_cycles: got %0d expected %0d", bc, LAT); end
    checks++; if (qg !== 8'd14) begin errors++; $display("[TB] FAIL u100_7_q: got %0d expected 14", qg); end
    checks++; if (rg !== 8'd2) begin errors++; $display("[TB] FAIL u100_7_r: got %0d expected 2", rg); end
    checks++; if (dzg !== 1'b0) begin errors++; $display("[TB] FAIL u100_7_dz: got %b expected 0", dzg); end
  endtask

  task automatic test_signed();
    logic [W-1:0] qg, rg;
    logic dzg;
    int lat, bc;
    doOp(1'b1, 8'h9C, 8'h07, qg, rg, dzg, lat, bc);
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL s_neg100_7_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (qg !== 8'hF2) begin errors++; $display("[TB] FAIL s_neg100_7_q: got %h expected f2", qg); end
    checks++; if (rg !== 8'hFE) begin errors++; $display("[TB] FAIL s_neg100_7_r: got %h expected fe", rg); end
    doOp(1'b1, 8'h80, 8'hFF, qg, rg, dzg, lat, bc);
    checks++; if (qg !== 8'h80) begin errors++; $display("[TB] FAIL s_overflow_q: got %h expected 80", qg); end
    checks++; if (rg !== 8'h00) begin errors++; $display("[TB] FAIL s_overflow_r: got %h expected 00", rg); end
    checks++; if (dzg !== 1'b0) begin errors++; $display("[TB] FAIL s_overflow_dz: got %b expected 0", dzg); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] qg, rg;
    logic dzg;
    int lat, bc;
    for (int m = 0; m < 2; m++) begin
      doOp(m[0], 8'h5A, 8'h00, qg, rg, dzg, lat, bc);
      checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL dz_latency_mode%0d: got %0d expected %0d", m, lat, LAT); end
      checks++; if (dzg !== 1'b1) begin errors++; $display("[TB] FAIL dz_flag_mode%0d: got %b expected 1", m, dzg); end
      checks++; if (qg !== 8'hFF) begin errors++; $display("[TB] FAIL dz_q_mode%0d: got %h expected ff", m, qg); end
      checks++; if (rg !== 8'h5A) begin errors++; $display("[TB] FAIL dz_r_mode%0d: got %h expected 5a", m, rg); end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    dif.start = 1'b1;
    dif.sgn = 1'b0;
    dif.a = 8'd100;
    dif.b = 8'd7;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dif.start = 1'b1;
    dif.a = 8'd200;
    dif.b = 8'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    lat = -1;
    for (int k = 5; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (dif.done) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL ignore_calc_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (dif.q !== 8'd14) begin errors++; $display("[TB] FAIL ignore_calc_q: got %0d expected 14", dif.q); end
    checks++; if (dif.r !== 8'd2) begin errors++; $display("[TB] FAIL ignore_calc_r: got %0d expected 2", dif.r); end
    dif.start = 1'b1;
    dif.a = 8'd200;
    dif.b = 8'd3;
    @(posedge clk);
    #1;
    dif.a = 8'd50;
    dif.b = 8'd5;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_done_busy: got %b expected 0", dif.busy); end
    checks++; if (dif.q !== 8'd14) begin errors++; $display("[TB] FAIL hold_q_after_done: got %0d expected 14", dif.q); end
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (dif.done) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL next_start_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (dif.q !== 8'd10) begin errors++; $display("[TB] FAIL next_start_q: got %0d expected 10", dif.q); end
    checks++; if (dif.r !== 8'd0) begin errors++; $display("[TB] FAIL next_start_r: got %0d expected 0", dif.r); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] qg, rg;
    logic dzg;
    int lat, bc;
    bit sawDone;
    dif.start = 1'b1;
    dif.sgn = 1'b0;
    dif.a = 8'd100;
    dif.b = 8'd7;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", dif.busy); end
    checks++; if (dif.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", dif.done); end
    checks++; if (dif.dz !== 1'b0) begin errors++; $display("[TB] FAIL abort_dz: got %b expected 0", dif.dz); end
    checks++; if (dif.q !== 8'h00) begin errors++; $display("[TB] FAIL abort_q: got %h expected 00", dif.q); end
    checks++; if (dif.r !== 8'h00) begin errors++; $display("[TB] FAIL abort_r: got %h expected 00", dif.r); end
    sawDone = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (dif.done) sawDone = 1'b1;
    end
    checks++; if (sawDone) begin errors++; $display("[TB] FAIL abort_no_done: got done=1 expected none"); end
    doOp(1'b0, 8'd255, 8'd16, qg, rg, dzg, lat, bc);
    checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL after_abort_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (qg !== 8'd15) begin errors++; $display("[TB] FAIL after_abort_q: got %0d expected 15", qg); end
    checks++; if (rg !== 8'd15) begin errors++; $display("[TB] FAIL after_abort_r: got %0d expected 15", rg); end
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] av, bv, qg, rg, qe, re, recon;
    logic s, dzg, dze;
    int lat, bc, sel, rr, bb, absR, absB;
    for (int i = 0; i < n; i++) begin
      s = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      av = W'($urandom);
      bv = W'($urandom);
      if (sel == 0) bv = '0;
      if (sel == 1) begin
        av = 8'h80;
        bv = 8'hFF;
      end
      model(s, av, bv, qe, re, dze);
      doOp(s, av, bv, qg, rg, dzg, lat, bc);
      checks++; if (lat != LAT) begin errors++; $display("[TB] FAIL rnd_latency #%0d: got %0d expected %0d", i, lat, LAT); end
      checks++; if (qg !== qe) begin errors++; $display("[TB] FAIL rnd_q #%0d sgn=%b a=%h b=%h: got %h expected %h", i, s, av, bv, qg, qe); end
      checks++; if (rg !== re) begin errors++; $display("[TB] FAIL rnd_r #%0d sgn=%b a=%h b=%h: got %h expected %h", i, s, av, bv, rg, re); end
      checks++; if (dzg !== dze) begin errors++; $display("[TB] FAIL rnd_dz #%0d: got %b expected %b", i, dzg, dze); end
      if (bv != '0) begin
        recon = W'(qg * bv + rg);
        checks++; if (recon !== av) begin errors++; $display("[TB] FAIL rnd_identity #%0d: got q*b+r=%h expected %h", i, recon, av); end
        rr = s ? int'($signed(rg)) : int'(rg);
        bb = s ? int'($signed(bv)) : int'(bv);
        absR = (rr < 0) ? -rr : rr;
        absB = (bb < 0) ? -bb : bb;
        checks++; if (!(absR < absB)) begin errors++; $display("[TB] FAIL rnd_rem_bound #%0d: got |r|=%0d expected below %0d", i, absR, absB); end
      end
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    rst = 1'b0;
    dif.start = 1'b0;
    dif.sgn = 1'b0;
    dif.a = '0;
    dif.b = '0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_random(2500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
